// File: rtl/cisr_acc_pipe.sv
// Per-channel row accumulator for a CISR sparse matrix-vector back end.
// Each multiplier channel owns an independent IDLE/BUSY/DONE machine. A
// channel pulls a row length, sums that many signed products from its own
// FIFO, and then offers the finished row sum to a shared output port.
// Loads and output selection both use fixed lowest-index-first priority.
module cisr_acc_pipe #(
  parameter int CHANNEL_NUM      = 4,
  parameter int ROW_LEN_SIZE     = 8,
  parameter int MULT_SIZE        = 16,
  parameter int ACCUMULATOR_SIZE = 32,
  parameter int ROW_ID_SIZE      = 8,
  parameter int SATURATE         = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ROW_LEN_SIZE*CHANNEL_NUM-1:0]  row_len_fifo_data,
  input  logic [CHANNEL_NUM-1:0]               row_len_fifo_empty,
  output logic [CHANNEL_NUM-1:0]               row_len_fifo_read,
  input  logic [MULT_SIZE*CHANNEL_NUM-1:0]     mult_fifo_data,
  input  logic [CHANNEL_NUM-1:0]               mult_fifo_empty,
  output logic [CHANNEL_NUM-1:0]               mult_fifo_read,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ROW_ID_SIZE-1:0]               out_row_id,
  output logic [ACCUMULATOR_SIZE-1:0]          out_data,
  output logic                                 out_overflow
);

  localparam int AW = ACCUMULATOR_SIZE;

  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } ch_state_t;

  // Per-channel architectural state.
  ch_state_t                   state  [CHANNEL_NUM];
  logic [ROW_LEN_SIZE-1:0]     cnt    [CHANNEL_NUM];
  logic [ROW_ID_SIZE-1:0]      row_id [CHANNEL_NUM];
  logic signed [AW-1:0]        acc    [CHANNEL_NUM];
  logic                        ovf    [CHANNEL_NUM];
  logic [ROW_ID_SIZE-1:0]      next_id;

  // Per-channel arithmetic results and the one-hot output pick.
  logic signed [AW:0]          sum_x   [CHANNEL_NUM];
  logic signed [AW-1:0]        sum_fit [CHANNEL_NUM];
  logic                        sum_ovf [CHANNEL_NUM];
  logic [CHANNEL_NUM-1:0]      out_pick;

  // One guard bit above the accumulator is enough: the product is never
  // wider than the accumulator, so a single add cannot exceed AW+1 bits.
  function automatic logic signed [AW:0] widen_add(
    input logic signed [AW-1:0]        a,
    input logic signed [MULT_SIZE-1:0] p
  );
    logic signed [AW:0] a_w;
    logic signed [AW:0] p_w;
    a_w = {a[AW-1], a};
    p_w = {{(AW+1-MULT_SIZE){p[MULT_SIZE-1]}}, p};
    return a_w + p_w;
  endfunction

  // The widened sum left the signed range when its two top bits disagree.
  function automatic logic sum_overflow(input logic signed [AW:0] s);
    return s[AW] ^ s[AW-1];
  endfunction

  // Narrow the widened sum back to the accumulator: wrap or clamp.
  function automatic logic signed [AW-1:0] fit_sum(input logic signed [AW:0] s);
    if ((SATURATE != 0) && sum_overflow(s)) begin
      return s[AW] ? ACC_MIN : ACC_MAX;
    end
    return s[AW-1:0];
  endfunction

  // Load arbiter: only the lowest-index idle channel with a length waiting pops it.
  always_comb begin
    logic found;
    found             = 1'b0;
    row_len_fifo_read = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      if (!rst && !found && (state[c] == ST_IDLE) && !row_len_fifo_empty[c]) begin
        row_len_fifo_read[c] = 1'b1;
        found                = 1'b1;
      end
    end
  end

  // Product pop: a busy channel consumes whenever its FIFO has a word.
  always_comb begin
    mult_fifo_read = '0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      mult_fifo_read[c] = !rst && (state[c] == ST_BUSY) && !mult_fifo_empty[c];
    end
  end

  // Accumulate path per channel: widened add, overflow detect, wrap/clamp.
  always_comb begin
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      sum_x[c]   = widen_add(acc[c], mult_fifo_data[c*MULT_SIZE +: MULT_SIZE]);
      sum_ovf[c] = sum_overflow(sum_x[c]);
      sum_fit[c] = fit_sum(sum_x[c]);
    end
  end

  // Output mux: present the lowest-index finished channel.
  always_comb begin
    logic found;
    found        = 1'b0;
    out_pick     = '0;
    out_valid    = 1'b0;
    out_row_id   = '0;
    out_data     = '0;
    out_overflow = 1'b0;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      if (!found && (state[c] == ST_DONE)) begin
        found        = 1'b1;
        out_pick[c]  = 1'b1;
        out_valid    = 1'b1;
        out_row_id   = row_id[c];
        out_data     = acc[c];
        out_overflow = ovf[c];
      end
    end
  end

  // Channel state machines and the shared row-id counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        state[c]  <= ST_IDLE;
        cnt[c]    <= '0;
        row_id[c] <= '0;
        acc[c]    <= '0;
        ovf[c]    <= 1'b0;
      end
      next_id <= '0;
    end else begin
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        case (state[c])
          ST_IDLE: begin
            if (row_len_fifo_read[c]) begin
              cnt[c]    <= row_len_fifo_data[c*ROW_LEN_SIZE +: ROW_LEN_SIZE];
              acc[c]    <= '0;
              ovf[c]    <= 1'b0;
              row_id[c] <= next_id;
              // An empty row has nothing to sum and is finished at once.
              if (row_len_fifo_data[c*ROW_LEN_SIZE +: ROW_LEN_SIZE] == '0) begin
                state[c] <= ST_DONE;
              end else begin
                state[c] <= ST_BUSY;
              end
            end
          end
          ST_BUSY: begin
            if (mult_fifo_read[c]) begin
              acc[c] <= sum_fit[c];
              ovf[c] <= ovf[c] | sum_ovf[c];
              cnt[c] <= cnt[c] - ROW_LEN_SIZE'(1);
              if (cnt[c] == ROW_LEN_SIZE'(1)) begin
                state[c] <= ST_DONE;
              end
            end
          end
          ST_DONE: begin
            // Results are held until the sink takes this channel's row.
            if (out_pick[c] && out_ready) begin
              state[c] <= ST_IDLE;
            end
          end
          default: begin
            state[c] <= ST_IDLE;
          end
        endcase
      end
      if (|row_len_fifo_read) begin
        next_id <= next_id + ROW_ID_SIZE'(1);
      end
    end
  end

endmodule

// File: tb/tb_cisr_acc_pipe.sv
// Bench for cisr_acc_pipe: a 4-channel wrapping instance driven from queue
// FIFOs against a row-level reference model, plus two narrow 16-bit
// instances (wrap and saturate) for accumulator overflow behaviour.
module tb_cisr_acc_pipe;

  localparam int CH = 4;
  localparam int LW = 8;
  localparam int MW = 16;
  localparam int AW = 32;
  localparam int IW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance signals.
  logic              rst = 1'b1;
  logic [LW*CH-1:0]  len_data = '0;
  logic [CH-1:0]     len_empty = '1;
  logic [CH-1:0]     len_rd;
  logic [MW*CH-1:0]  mult_data = '0;
  logic [CH-1:0]     mult_empty = '1;
  logic [CH-1:0]     mult_rd;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [IW-1:0]     out_row_id;
  logic [AW-1:0]     out_data;
  logic              out_overflow;

  cisr_acc_pipe #(
    .CHANNEL_NUM(CH), .ROW_LEN_SIZE(LW), .MULT_SIZE(MW),
    .ACCUMULATOR_SIZE(AW), .ROW_ID_SIZE(IW), .SATURATE(0)
  ) u_dut (
    .clk(clk), .rst(rst),
    .row_len_fifo_data(len_data), .row_len_fifo_empty(len_empty), .row_len_fifo_read(len_rd),
    .mult_fifo_data(mult_data), .mult_fifo_empty(mult_empty), .mult_fifo_read(mult_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_row_id(out_row_id),
    .out_data(out_data), .out_overflow(out_overflow)
  );

  // Narrow instances share one stimulus.
  logic        s_rst = 1'b1;
  logic [15:0] s_len_data = '0;
  logic [1:0]  s_len_empty = '1;
  logic [31:0] s_mult_data = '0;
  logic [1:0]  s_mult_empty = '1;
  logic        s_ready = 1'b0;
  logic [1:0]  w_len_rd, w_mult_rd, t_len_rd, t_mult_rd;
  logic        w_valid, w_ovf, t_valid, t_ovf;
  logic [7:0]  w_id, t_id;
  logic [15:0] w_data, t_data;

  cisr_acc_pipe #(
    .CHANNEL_NUM(2), .ROW_LEN_SIZE(8), .MULT_SIZE(16),
    .ACCUMULATOR_SIZE(16), .ROW_ID_SIZE(8), .SATURATE(0)
  ) u_wrap (
    .clk(clk), .rst(s_rst),
    .row_len_fifo_data(s_len_data), .row_len_fifo_empty(s_len_empty), .row_len_fifo_read(w_len_rd),
    .mult_fifo_data(s_mult_data), .mult_fifo_empty(s_mult_empty), .mult_fifo_read(w_mult_rd),
    .out_valid(w_valid), .out_ready(s_ready), .out_row_id(w_id),
    .out_data(w_data), .out_overflow(w_ovf)
  );

  cisr_acc_pipe #(
    .CHANNEL_NUM(2), .ROW_LEN_SIZE(8), .MULT_SIZE(16),
    .ACCUMULATOR_SIZE(16), .ROW_ID_SIZE(8), .SATURATE(1)
  ) u_sat (
    .clk(clk), .rst(s_rst),
    .row_len_fifo_data(s_len_data), .row_len_fifo_empty(s_len_empty), .row_len_fifo_read(t_len_rd),
    .mult_fifo_data(s_mult_data), .mult_fifo_empty(s_mult_empty), .mult_fifo_read(t_mult_rd),
    .out_valid(t_valid), .out_ready(s_ready), .out_row_id(t_id),
    .out_data(t_data), .out_overflow(t_ovf)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // FIFO contents the bench offers, per channel.
  int lenq  [CH][$];
  int prodq [CH][$];

  // Reference model: per channel, the row it holds and how much is left.
  bit           m_act  [CH];
  int           m_rem  [CH];
  logic [AW-1:0] m_sum [CH];
  bit           m_ovf  [CH];
  logic [IW-1:0] m_id  [CH];
  logic [IW-1:0] m_next;

  int len_pct  = 100;
  int prod_pct = 100;
  int rdy_pct  = 100;
  logic [CH-1:0] hold_mult = '0;

  // Results actually accepted by the sink, in order.
  int            log_id   [$];
  logic [AW-1:0] log_data [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_act[c] = 1'b0; m_rem[c] = 0; m_sum[c] = '0; m_ovf[c] = 1'b0; m_id[c] = '0;
    end
    m_next = '0;
  endtask

  task automatic clear_all();
    for (int c = 0; c < CH; c++) begin
      lenq[c].delete();
      prodq[c].delete();
    end
    log_id.delete();
    log_data.delete();
    hold_mult = '0;
  endtask

  // One clock of the main instance: drive, compare against the model, advance.
  task automatic cycle(input bit rs);
    logic [CH-1:0] le, me, elr, emr;
    bit rdy, ev, found;
    int sel, len;
    longint s;
    longint amax, amin;
    amax = (longint'(1) <<< (AW-1)) - 1;
    amin = -(longint'(1) <<< (AW-1));
    @(negedge clk);
    rst = rs;
    rdy = ($urandom_range(99) < rdy_pct);
    out_ready = rdy;
    for (int c = 0; c < CH; c++) begin
      le[c] = !((lenq[c].size() > 0) && ($urandom_range(99) < len_pct));
      len_data[c*LW +: LW] = (lenq[c].size() > 0) ? LW'(lenq[c][0]) : '0;
      me[c] = !((prodq[c].size() > 0) && ($urandom_range(99) < prod_pct) && !hold_mult[c]);
      mult_data[c*MW +: MW] = (prodq[c].size() > 0) ? MW'(prodq[c][0]) : '0;
    end
    len_empty  = le;
    mult_empty = me;
    #1;
    elr = '0; emr = '0; found = 1'b0; ev = 1'b0; sel = 0;
    for (int c = 0; c < CH; c++) begin
      if (!rs && !found && !m_act[c] && !le[c]) begin elr[c] = 1'b1; found = 1'b1; end
      if (!rs && m_act[c] && (m_rem[c] > 0) && !me[c]) emr[c] = 1'b1;
      if (!ev && m_act[c] && (m_rem[c] == 0)) begin ev = 1'b1; sel = c; end
    end
    chk("len_read", 64'(len_rd), 64'(elr));
    chk("mult_read", 64'(mult_rd), 64'(emr));
    chk("out_valid", 64'(out_valid), 64'(ev));
    if (ev) begin
      chk("out_row_id", 64'(out_row_id), 64'(m_id[sel]));
      chk("out_data", 64'(out_data), 64'(m_sum[sel]));
      chk("out_overflow", 64'(out_overflow), 64'(m_ovf[sel]));
    end
    if (!rs && out_valid && rdy) begin
      log_id.push_back(int'(out_row_id));
      log_data.push_back(out_data);
    end
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
      if (ev && rdy) m_act[sel] = 1'b0;
      for (int c = 0; c < CH; c++) begin
        if (emr[c]) begin
          s = longint'($signed(m_sum[c])) + longint'(prodq[c].pop_front());
          if (s > amax || s < amin) m_ovf[c] = 1'b1;
          m_sum[c] = s[AW-1:0];
          m_rem[c]--;
        end
        if (elr[c]) begin
          len = lenq[c].pop_front();
          m_act[c] = 1'b1; m_rem[c] = len; m_sum[c] = '0; m_ovf[c] = 1'b0;
          m_id[c] = m_next;
          m_next++;
        end
      end
    end
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (log_id.size() < target && k < budget) begin
      cycle(1'b0);
      k++;
    end
    chk(tag, 64'(log_id.size()), 64'(target));
  endtask

  // One two-product row through both narrow instances.
  task automatic ovf_row(input logic [15:0] p1, input logic [15:0] p2,
                         input logic [15:0] exp_w, input logic [15:0] exp_t,
                         input logic [7:0] id);
    @(negedge clk);
    s_ready = 1'b0; s_len_empty = 2'b10; s_len_data = 16'h0002; s_mult_empty = 2'b11;
    #1;
    chk("narrow_len_read", 64'({w_len_rd, t_len_rd}), 64'(4'b0101));
    @(negedge clk);
    s_len_empty = 2'b11; s_mult_empty = 2'b10; s_mult_data = {16'h0000, p1};
    @(negedge clk);
    s_mult_data = {16'h0000, p2};
    @(negedge clk);
    s_mult_empty = 2'b11;
    #1;
    chk("narrow_valid", 64'({w_valid, t_valid}), 64'(2'b11));
    chk("wrap_data", 64'(w_data), 64'(exp_w));
    chk("sat_data", 64'(t_data), 64'(exp_t));
    chk("narrow_ovf", 64'({w_ovf, t_ovf}), 64'(2'b11));
    chk("narrow_id", 64'({w_id, t_id}), 64'({id, id}));
    s_ready = 1'b1;
    @(negedge clk);
    s_ready = 1'b0;
    #1;
    chk("narrow_released", 64'({w_valid, t_valid}), 64'(2'b00));
  endtask

  initial begin
    int exp_ids [4];
    logic [AW-1:0] exp_dat [4];
    int cnt0, cnt255, left, total, len;

    // Power-up: settle both resets before any checking.
    rst = 1'b1; s_rst = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();

    // Overflow on the 16-bit instances: positive then negative excursion.
    @(negedge clk);
    s_rst = 1'b0;
    ovf_row(16'h7FFF, 16'h0001, 16'h8000, 16'h7FFF, 8'd0);
    ovf_row(16'h8000, 16'hFFFF, 16'h7FFF, 16'h8000, 8'd1);

    // Lengths {2,0,1,3} waiting during reset, every product 5.
    clear_all();
    lenq[0].push_back(2); lenq[1].push_back(0); lenq[2].push_back(1); lenq[3].push_back(3);
    repeat (2) prodq[0].push_back(5);
    prodq[2].push_back(5);
    repeat (3) prodq[3].push_back(5);
    len_pct = 100; prod_pct = 100; rdy_pct = 100;
    cycle(1'b1); cycle(1'b1);
    run_until(4, 40, "basic_drain");
    exp_ids = '{1, 0, 2, 3};
    exp_dat = '{32'd0, 32'd10, 32'd5, 32'd15};
    for (int i = 0; i < 4 && i < log_id.size(); i++) begin
      chk("basic_order_id", 64'(log_id[i]), 64'(exp_ids[i]));
      chk("basic_order_data", 64'(log_data[i]), 64'(exp_dat[i]));
    end

    // Product FIFO stalls for two cycles in the middle of a row.
    clear_all();
    lenq[0].push_back(3);
    prodq[0].push_back(1); prodq[0].push_back(2); prodq[0].push_back(3);
    cycle(1'b1); cycle(1'b1);
    cycle(1'b0); cycle(1'b0);
    hold_mult = 4'b0001;
    cycle(1'b0); cycle(1'b0);
    hold_mult = '0;
    run_until(1, 20, "stall_drain");
    repeat (3) cycle(1'b0);
    chk("stall_single", 64'(log_id.size()), 64'(1));
    if (log_data.size() > 0) chk("stall_sum", 64'(log_data[0]), 64'(6));

    // Back-pressure with channels 0 and 2 both finished.
    clear_all();
    lenq[0].push_back(1); lenq[2].push_back(1);
    prodq[0].push_back(7); prodq[2].push_back(9);
    rdy_pct = 0;
    cycle(1'b1); cycle(1'b1);
    repeat (9) cycle(1'b0);
    chk("hold_none_taken", 64'(log_id.size()), 64'(0));
    rdy_pct = 100;
    run_until(2, 10, "hold_drain");
    if (log_id.size() == 2) begin
      chk("hold_first_id", 64'(log_id[0]), 64'(0));
      chk("hold_first_data", 64'(log_data[0]), 64'(7));
      chk("hold_second_id", 64'(log_id[1]), 64'(1));
      chk("hold_second_data", 64'(log_data[1]), 64'(9));
    end

    // 257 empty rows: row id must wrap past 255.
    clear_all();
    for (int i = 0; i < 257; i++) lenq[i % CH].push_back(0);
    cycle(1'b1); cycle(1'b1);
    run_until(257, 3000, "wrap_drain");
    cnt0 = 0; cnt255 = 0;
    foreach (log_id[i]) begin
      if (log_id[i] == 0) cnt0++;
      if (log_id[i] == 255) cnt255++;
    end
    chk("wrap_id0_count", 64'(cnt0), 64'(2));
    chk("wrap_id255_count", 64'(cnt255), 64'(1));

    // Reset in the middle of a busy row discards it; ids restart at 0.
    clear_all();
    lenq[0].push_back(4);
    repeat (4) prodq[0].push_back(int'($urandom_range(0, 65535)) - 32768);
    cycle(1'b0); cycle(1'b0); cycle(1'b0);
    cycle(1'b1);
    cycle(1'b0);
    lenq[1].push_back(0);
    run_until(1, 10, "after_reset_drain");
    if (log_id.size() > 0) chk("after_reset_id", 64'(log_id[0]), 64'(0));

    // Randomised traffic with random FIFO gaps and sink back-pressure.
    clear_all();
    total = 0;
    for (int c = 0; c < CH; c++) begin
      for (int r = 0; r < 6; r++) begin
        len = int'($urandom_range(0, 5));
        lenq[c].push_back(len);
        for (int k = 0; k < len; k++) prodq[c].push_back(int'($urandom_range(0, 65535)) - 32768);
        total++;
      end
    end
    len_pct = 70; prod_pct = 70; rdy_pct = 60;
    cycle(1'b1); cycle(1'b1);
    run_until(total, 3000, "rand_drain");
    left = 0;
    for (int c = 0; c < CH; c++) left += prodq[c].size() + lenq[c].size();
    chk("rand_fifos_drained", 64'(left), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
